// File: rtl/sdp_bram_bw_clr.sv
// Single-clock simple-dual-port RAM with byte-write enables and a post-reset
// zero-fill sequencer; port A writes, port B reads.
module sdp_bram_bw_clr #(
    parameter int LEN_DATA    = 32,
    parameter int LEN_ADDR    = 8,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [LEN_DATA/8-1:0] wea,
    input  logic [LEN_ADDR-1:0] addra,
    input  logic [LEN_DATA-1:0] dina,
    input  logic                enb,
    input  logic [LEN_ADDR-1:0] addrb,
    output logic [LEN_DATA-1:0] doutb,
    output logic                doutb_valid,
    output logic                busy
);

    localparam int NB    = LEN_DATA / 8;
    localparam int DEPTH = 2 ** LEN_ADDR;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state;
    logic [LEN_ADDR-1:0] clr_addr;
    logic                busy_q;

    logic [LEN_DATA-1:0] ram [DEPTH];

    logic                clr_we;
    logic                wr_acc;
    logic                rd_acc;
    logic [LEN_DATA-1:0] rd_word;

    logic [LEN_DATA-1:0] d1;
    logic                v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + LEN_ADDR'(1);
                    if (clr_addr == '1) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= S_CLEAR;
                    clr_addr <= '0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    // Nothing is accepted on a reset edge, so rst also gates the strobes.
    assign clr_we = (state == S_CLEAR) && !rst;
    assign wr_acc = (state == S_IDLE) && !rst && ena;
    assign rd_acc = (state == S_IDLE) && !rst && enb;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    ram[addra][8*i +: 8] <= dina[8*i +: 8];
                end
            end
        end
    end

    // Same-address collision: merge only the lanes being written.
    always_comb begin
        rd_word = ram[addrb];
        if ((WRITE_FIRST != 0) && wr_acc && (addra == addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    rd_word[8*i +: 8] = dina[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                d1 <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LEN_DATA-1:0] d2;
            logic                v2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign doutb       = d2;
            assign doutb_valid = v2;
        end else begin : g_noreg
            assign doutb       = d1;
            assign doutb_valid = v1;
        end
    endgenerate

    assign busy = busy_q | rst;

endmodule

// File: doc/sdp_bram_bw_clr.md
# sdp_bram_bw_clr

Single-clock simple-dual-port block RAM with per-byte write enables, a selectable read-during-write policy, an optional output register and a post-reset hardware clear sequencer. It replaces the unmasked two-clock RAM wherever the cache and TLB arrays need byte-masked stores and guaranteed-zero contents after every reset. Port A is write-only and port B is read-only.

## Interface
- LEN_DATA, 32, word width in bits; must be a multiple of 8
- LEN_ADDR, 8, address width; DEPTH = 2**LEN_ADDR
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- WRITE_FIRST, 1, same-address read-during-write policy: 1 = new data, 0 = old data
- NB (derived), LEN_DATA/8 byte lanes

Ports:
- clk  in  1  the only clock; all logic samples on its rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  port A write enable qualifier
- wea  in  NB  per-byte write enables; bit i covers dina[8i+7:8i]
- addra  in  LEN_ADDR  write address
- dina  in  LEN_DATA  write data
- enb  in  1  port B read request
- addrb  in  LEN_ADDR  read address
- doutb  out  LEN_DATA  read data
- doutb_valid  out  1  one-cycle pulse aligned with new doutb data
- busy  out  1  clear sequence in progress; requests ignored

## Operation
- FSM states: CLEAR and IDLE.
  - Reset enters CLEAR with clr_addr = 0.
  - CLEAR writes all-zero to ram[clr_addr] on every edge and increments clr_addr.
  - CLEAR moves to IDLE on the edge that writes DEPTH-1.
- busy = 1 while in reset or CLEAR, and 0 in IDLE.
- While busy, ena/wea and enb are ignored: no user write and no doutb_valid.
- Write: at an edge in IDLE with ena=1, each byte lane i with wea[i]=1 takes the matching dina byte. Lanes with wea[i]=0 are unchanged. ena=1 with wea=0 is a no-op.
- Read: at an edge in IDLE with enb=1, ram[addrb] is captured. doutb holds its last value when no read is accepted.
- Read-during-write, when addra == addrb and both are accepted on the same edge:
  - WRITE_FIRST=1: captured word = per-byte merge. Bytes with wea set come from dina; the others come from the old contents.
  - WRITE_FIRST=0: captured word = old contents.
  - Different addresses do not interact.
- OUT_REG=1 adds one register stage to doutb and doutb_valid. Back-to-back reads give one result per cycle.
- Reset during CLEAR or IDLE:
  - Restarts CLEAR from address 0.
  - Drops in-flight reads; no doutb_valid is produced for them.
  - RAM contents are not otherwise touched by rst itself.

## Timing
- Reset values while rst=1: doutb = 0, doutb_valid = 0, busy = 1, state = CLEAR, clr_addr = 0. All output-pipeline stages are zeroed.
- Edge numbering: E0 = first rising edge with rst=0.
  - E0..E(DEPTH-1) clear addresses 0..DEPTH-1.
  - busy falls after E(DEPTH-1).
  - The first user request is accepted at E(DEPTH).
- OUT_REG=0: a read accepted at edge En drives doutb after En. doutb_valid is high for the cycle between En and En+1.
- OUT_REG=1: the same data appears one edge later (after En+1), with doutb_valid high for that one cycle.
- A write at En is visible to a different-address read accepted at En+1 or later.
- Throughput: one write plus one read per cycle in IDLE; there is no backpressure.

## Test plan
- Clear: DEPTH=256, preload ram[5] = 0xDEADBEEF via a prior run, then pulse rst.
  - busy stays high for exactly 256 edges after rst deassert.
  - A read of address 5 then returns 0x00000000.
- Byte mask: write 0x11223344 to addr 3 with wea=4'b1111, then wea=4'b0101 with dina=0xAABBCCDD.
  - A read of addr 3 returns 0x11BB33DD.
- Read-during-write: ram[7]=0x11223344. Same edge: write addr 7 with wea=4'b0011, dina=0xAABBCCDD, and read addr 7.
  - WRITE_FIRST=1 → doutb = 0x1122CCDD.
  - WRITE_FIRST=0 → doutb = 0x11223344.
  - A subsequent read returns 0x1122CCDD in both modes.
- Latency and streaming: reads of addrs 0,1,2 on consecutive edges, with contents 0xA,0xB,0xC.
  - OUT_REG=0: doutb_valid high for 3 consecutive cycles starting 1 cycle after the first request.
  - OUT_REG=1: the same, starting 2 cycles after the first request.
  - Data are in order in both cases.
- Busy gating: during CLEAR, assert ena=1, wea=4'b1111, addra=200, dina=0x55555555, and enb=1.
  - No doutb_valid pulse.
  - After clear completes, a read of addr 200 returns 0.
- Mid-clear reset: assert rst for 1 cycle at edge E100 of a clear.
  - busy stays high for a fresh 256 edges.
  - All addresses read 0 afterwards.
  - doutb = 0 and doutb_valid = 0 during rst.
